// File: rtl/aes_ofifo_packer_if.sv
// rtl/aes_ofifo_packer_if.sv - byte-in / word-out bundle for the AES output packer
//
// Purpose: groups the AES-core byte stream, flush request, output-FIFO write
//          port and status signals of aes_ofifo_packer into one bundle.
// Signals:
//   aes_dout   [7:0]  ciphertext byte from the AES core
//   aes_vld           aes_dout valid; the core is never stalled
//   flush             1-cycle pulse requesting emission of a partial word
//   ofifo_full        output FIFO full (backpressure)
//   ofifo_wr          write strobe to the output FIFO
//   ofifo_din  [31:0] packed little-endian word
//   ofifo_be   [3:0]  byte enables for ofifo_din
//   buf_level         byte-buffer occupancy
//   overflow          sticky byte-drop indicator
// Modports: master = environment side (AES core + output FIFO), slave = packer.
// BUF_DEPTH must match the BUF_DEPTH of the packer instance it connects to.

interface aes_ofifo_packer_if #(
   parameter int BUF_DEPTH = 16
);
   logic [7:0]                 aes_dout;
   logic                       aes_vld;
   logic                       flush;
   logic                       ofifo_full;
   logic                       ofifo_wr;
   logic [31:0]                ofifo_din;
   logic [3:0]                 ofifo_be;
   logic [$clog2(BUF_DEPTH):0] buf_level;
   logic                       overflow;

   modport master (
      output aes_dout, aes_vld, flush, ofifo_full,
      input  ofifo_wr, ofifo_din, ofifo_be, buf_level, overflow
   );

   modport slave (
      input  aes_dout, aes_vld, flush, ofifo_full,
      output ofifo_wr, ofifo_din, ofifo_be, buf_level, overflow
   );
endinterface

// File: rtl/aes_ofifo_packer.sv
// rtl/aes_ofifo_packer.sv - elastic byte buffer + little-endian 32-bit packer for the AES core
//
// Purpose: captures every byte the (unstallable) AES core emits into a circular
//          byte buffer, packs bytes little-endian into 32-bit words and writes
//          them to the output FIFO through a single hold register. Partial
//          words leave with a byte-enable mask on flush or after an idle timeout.
// Ports:
//   clock   rising-edge clock
//   rst     asynchronous active-low reset
//   bus     aes_ofifo_packer_if.slave (byte input, flush, FIFO write port, status)
// Parameters:
//   BUF_DEPTH      byte-buffer entries, power of 2, >= 4
//   FLUSH_TIMEOUT  idle cycles with a partial word before auto-flush; 0 disables

module aes_ofifo_packer #(
   parameter int BUF_DEPTH     = 16,
   parameter int FLUSH_TIMEOUT = 64
) (
   input  logic              clock,
   input  logic              rst,
   aes_ofifo_packer_if.slave bus
);
   localparam int          AW      = $clog2(BUF_DEPTH);
   localparam int          TW      = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
   localparam bit          TMO_EN  = (FLUSH_TIMEOUT > 0);
   localparam logic [TW-1:0] TMO_LIM = TW'(FLUSH_TIMEOUT);
   localparam logic [AW:0] DEPTH_L = (AW + 1)'(BUF_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_GATHER, S_FLUSH} state_t;

   logic [7:0]    mem [BUF_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, level;
   logic          buf_empty, buf_full;
   logic          push, pop, word_done;
   logic [7:0]    pop_byte;

   logic [23:0]   acc;
   logic [1:0]    cnt;

   logic          hold_vld, hold_free, wr;
   logic [31:0]   hold_din;
   logic [3:0]    hold_be;
   logic [3:0]    part_be;

   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit, tmo_run;
   logic          load_partial;
   logic          ovf;

   state_t        state, state_nxt;

   // ---------------- byte buffer ----------------
   assign level     = wr_ptr - rd_ptr;
   assign buf_empty = (wr_ptr == rd_ptr);
   assign buf_full  = (level == DEPTH_L);
   assign pop_byte  = mem[rd_ptr[AW-1:0]];

   // The hold register is free this cycle if it is empty or being written out.
   assign wr        = hold_vld & ~bus.ofifo_full;
   assign hold_free = ~hold_vld | wr;

   // Only the word-completing pop needs somewhere to go.
   assign pop       = ~buf_empty & ~((cnt == 2'd3) & ~hold_free);
   // A concurrent pop frees a slot, so a full buffer still accepts the byte.
   assign push      = bus.aes_vld & (~buf_full | pop);
   assign word_done = pop & (cnt == 2'd3);

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.aes_dout;
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (bus.aes_vld & ~push) ovf <= 1'b1;
      end
   end

   // ---------------- accumulator ----------------
   // Lanes are cleared whenever a word leaves, so {8'h0, acc} is already the
   // zero-padded partial word.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         cnt <= 2'd0;
      end else if (word_done || load_partial) begin
         acc <= '0;
         cnt <= 2'd0;
      end else if (pop) begin
         case (cnt)
            2'd0:    acc[7:0]   <= pop_byte;
            2'd1:    acc[15:8]  <= pop_byte;
            default: acc[23:16] <= pop_byte;
         endcase
         cnt <= cnt + 2'd1;
      end
   end

   always_comb begin
      part_be = 4'h0;
      case (cnt)
         2'd1:    part_be = 4'h1;
         2'd2:    part_be = 4'h3;
         2'd3:    part_be = 4'h7;
         default: part_be = 4'h0;
      endcase
   end

   // ---------------- hold register ----------------
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         hold_vld <= 1'b0;
         hold_din <= '0;
         hold_be  <= '0;
      end else if (word_done) begin
         hold_vld <= 1'b1;
         hold_din <= {pop_byte, acc};
         hold_be  <= 4'hF;
      end else if (load_partial) begin
         hold_vld <= 1'b1;
         hold_din <= {8'h00, acc};
         hold_be  <= part_be;
      end else if (wr) begin
         hold_vld <= 1'b0;
      end
   end

   // ---------------- idle timeout ----------------
   // Counts idle cycles in S_GATHER and saturates at the limit.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (!tmo_run) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LIM) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LIM) && !pop;

   // ---------------- FSM ----------------
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (pop) state_nxt = S_GATHER;
         end
         S_GATHER: begin
            // Flush wins over word completion so bytes still buffered are
            // covered by the flush.
            if (bus.flush || tmo_hit) state_nxt = S_FLUSH;
            else if (word_done)       state_nxt = S_IDLE;
         end
         S_FLUSH: begin
            if (buf_empty && ((cnt == 2'd0) || hold_free)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      load_partial = 1'b0;
      tmo_run      = 1'b0;
      case (state)
         S_GATHER: tmo_run      = ~pop;
         S_FLUSH:  load_partial = buf_empty & (cnt != 2'd0) & hold_free;
         default: ;
      endcase
   end

   // ---------------- outputs ----------------
   assign bus.ofifo_wr  = wr;
   assign bus.ofifo_din = hold_din;
   assign bus.ofifo_be  = hold_be;
   assign bus.buf_level = level;
   assign bus.overflow  = ovf;

endmodule
